// File: rtl/rc4_crack_sequencer_pkg.sv
// Shared types for the RC4 key-search sequencer: FSM states, phase select and
// S-memory geometry.
package rc4_pkg;

    localparam int KEY_W  = 24;
    localparam int MEM_AW = 8;
    localparam int MEM_DW = 8;

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT_RUN,
        S_INIT_GAP,
        S_KSA_RUN,
        S_KSA_GAP,
        S_PRGA_RUN,
        S_PRGA_GAP,
        S_CHECK,
        S_FOUND,
        S_FAIL
    } seq_state_t;

    typedef enum logic [1:0] {
        PH_NONE,
        PH_INIT,
        PH_KSA,
        PH_PRGA
    } phase_t;

    // Only the three RUN states own the memory port and an engine start.
    function automatic phase_t state_phase(input seq_state_t s);
        case (s)
            S_INIT_RUN: return PH_INIT;
            S_KSA_RUN:  return PH_KSA;
            S_PRGA_RUN: return PH_PRGA;
            default:    return PH_NONE;
        endcase
    endfunction

endpackage

// File: rtl/rc4_crack_sequencer_watchdog.sv
// Per-phase cycle counter; tc_o flags that the running phase has used up its
// cycle allowance.
module phase_watchdog #(
    parameter logic [15:0] PHASE_TIMEOUT = 16'd4095
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [15:0] count_q;
    logic [15:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = 16'd0;
        end else if (en_i) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 16'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == PHASE_TIMEOUT);

endmodule

// File: rtl/rc4_crack_sequencer.sv
// Phase controller for the RC4 key search: walks candidate keys through
// S-init, KSA and PRGA over one shared S memory and stops on a hit, end of
// key space or a hung phase.
module rc4_crack_sequencer
    import rc4_pkg::*;
#(
    parameter logic [KEY_W-1:0] KEY_FIRST     = 24'h000000,
    parameter logic [KEY_W-1:0] KEY_LAST      = 24'h3FFFFF,
    parameter logic [KEY_W-1:0] KEY_STEP      = 24'd1,
    parameter logic [15:0]      PHASE_TIMEOUT = 16'd4095
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              go,
    output logic [KEY_W-1:0]  secret_key,
    output logic              init_start,
    output logic              ksa_start,
    output logic              prga_start,
    input  logic              init_done,
    input  logic              ksa_done,
    input  logic              prga_done,
    input  logic              prga_ok,
    input  logic [MEM_AW-1:0] init_addr,
    input  logic [MEM_DW-1:0] init_data,
    input  logic              init_wren,
    input  logic [MEM_AW-1:0] ksa_addr,
    input  logic [MEM_DW-1:0] ksa_data,
    input  logic              ksa_wren,
    input  logic [MEM_AW-1:0] prga_addr,
    input  logic [MEM_DW-1:0] prga_data,
    input  logic              prga_wren,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [MEM_DW-1:0] mem_data,
    output logic              mem_wren,
    output logic              busy,
    output logic              found,
    output logic              exhausted,
    output logic              timeout_err
);

    seq_state_t       state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic             ok_q, ok_d;
    logic             found_q, found_d;
    logic             exh_q, exh_d;
    logic             to_q, to_d;
    logic             wd_tc;
    logic             run;
    phase_t           phase;

    assign phase = state_phase(state_q);
    assign run   = (phase != PH_NONE);

    phase_watchdog #(
        .PHASE_TIMEOUT(PHASE_TIMEOUT)
    ) u_watchdog (
        .clk  (clk),
        .rst_n(rst_n),
        .clr_i(!run),
        .en_i (run),
        .tc_o (wd_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            key_q   <= '0;
            ok_q    <= 1'b0;
            found_q <= 1'b0;
            exh_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            ok_q    <= ok_d;
            found_q <= found_d;
            exh_q   <= exh_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        ok_d    = ok_q;
        found_d = found_q;
        exh_d   = exh_q;
        to_d    = to_q;
        case (state_q)
            S_IDLE, S_FOUND, S_FAIL: begin
                if (go) begin
                    key_d   = KEY_FIRST;
                    ok_d    = 1'b0;
                    found_d = 1'b0;
                    exh_d   = 1'b0;
                    to_d    = 1'b0;
                    state_d = S_INIT_RUN;
                end
            end
            // A done arriving on the timeout cycle still counts as success.
            S_INIT_RUN: begin
                if (init_done) begin
                    state_d = S_INIT_GAP;
                end else if (wd_tc) begin
                    to_d    = 1'b1;
                    state_d = S_FAIL;
                end
            end
            S_KSA_RUN: begin
                if (ksa_done) begin
                    state_d = S_KSA_GAP;
                end else if (wd_tc) begin
                    to_d    = 1'b1;
                    state_d = S_FAIL;
                end
            end
            S_PRGA_RUN: begin
                if (prga_done) begin
                    ok_d    = prga_ok;
                    state_d = S_PRGA_GAP;
                end else if (wd_tc) begin
                    to_d    = 1'b1;
                    state_d = S_FAIL;
                end
            end
            S_INIT_GAP: state_d = S_KSA_RUN;
            S_KSA_GAP:  state_d = S_PRGA_RUN;
            S_PRGA_GAP: state_d = S_CHECK;
            S_CHECK: begin
                // 25-bit sum so a step past the top of the key space cannot wrap.
                if (ok_q) begin
                    found_d = 1'b1;
                    state_d = S_FOUND;
                end else if (({1'b0, key_q} + {1'b0, KEY_STEP}) > {1'b0, KEY_LAST}) begin
                    exh_d   = 1'b1;
                    state_d = S_FAIL;
                end else begin
                    key_d   = key_q + KEY_STEP;
                    state_d = S_INIT_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        init_start = 1'b0;
        ksa_start  = 1'b0;
        prga_start = 1'b0;
        mem_addr   = '0;
        mem_data   = '0;
        mem_wren   = 1'b0;
        case (phase)
            PH_INIT: begin
                init_start = 1'b1;
                mem_addr   = init_addr;
                mem_data   = init_data;
                mem_wren   = init_wren;
            end
            PH_KSA: begin
                ksa_start = 1'b1;
                mem_addr  = ksa_addr;
                mem_data  = ksa_data;
                mem_wren  = ksa_wren;
            end
            PH_PRGA: begin
                prga_start = 1'b1;
                mem_addr   = prga_addr;
                mem_data   = prga_data;
                mem_wren   = prga_wren;
            end
            default: ;
        endcase
        busy = !(state_q == S_IDLE || state_q == S_FOUND || state_q == S_FAIL);
    end

    assign secret_key  = key_q;
    assign found       = found_q;
    assign exhausted   = exh_q;
    assign timeout_err = to_q;

endmodule

// File: tb/tb_rc4_crack_sequencer.sv
// Bench for rc4_crack_sequencer: four differently parameterised instances,
// each driven by counting mock engines.
module tb_rc4_crack_sequencer;

    localparam int NI = 4;

    logic clk;
    logic        rst_a     [NI];
    logic        go_a      [NI];
    logic        ok_en_a   [NI];
    logic [23:0] ok_key_a  [NI];
    logic        stuck_a   [NI];
    logic [23:0] key_a     [NI];
    logic        ist_a     [NI];
    logic        kst_a     [NI];
    logic        pst_a     [NI];
    logic [7:0]  maddr_a   [NI];
    logic [7:0]  mdata_a   [NI];
    logic        mwren_a   [NI];
    logic        busy_a    [NI];
    logic        found_a   [NI];
    logic        exh_a     [NI];
    logic        to_a      [NI];

    int busy_cyc [NI];
    int att      [NI];
    logic prev_ist [NI];

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: full-size engines, defaults. 1/2: top of key space, step 1/2.
    // 3: short engines with PHASE_TIMEOUT=100.
    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam logic [15:0] LI = (g == 0) ? 16'd256  : 16'd20;
        localparam logic [15:0] LK = (g == 0) ? 16'd2560 : 16'd30;
        localparam logic [15:0] LP = (g == 0) ? 16'd600  : 16'd40;
        logic [15:0] icnt, kcnt, pcnt;
        logic id, kd, pd, pok;

        always_ff @(posedge clk) begin
            icnt <= ist_a[g] ? ((icnt == LI) ? icnt : icnt + 16'd1) : 16'd0;
            kcnt <= kst_a[g] ? ((kcnt == LK) ? kcnt : kcnt + 16'd1) : 16'd0;
            pcnt <= pst_a[g] ? ((pcnt == LP) ? pcnt : pcnt + 16'd1) : 16'd0;
        end

        assign id  = ist_a[g] && (icnt == LI);
        assign kd  = kst_a[g] && (kcnt == LK) && !stuck_a[g];
        assign pd  = pst_a[g] && (pcnt == LP);
        assign pok = pd && ok_en_a[g] && (key_a[g] == ok_key_a[g]);

        rc4_crack_sequencer #(
            .KEY_FIRST    ((g == 1 || g == 2) ? 24'h3FFFFE : 24'h000000),
            .KEY_LAST     (24'h3FFFFF),
            .KEY_STEP     ((g == 2) ? 24'd2 : 24'd1),
            .PHASE_TIMEOUT((g == 3) ? 16'd100 : 16'd4095)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_a[g]),
            .go         (go_a[g]),
            .secret_key (key_a[g]),
            .init_start (ist_a[g]),
            .ksa_start  (kst_a[g]),
            .prga_start (pst_a[g]),
            .init_done  (id),
            .ksa_done   (kd),
            .prga_done  (pd),
            .prga_ok    (pok),
            .init_addr  (icnt[7:0]),
            .init_data  (icnt[7:0] ^ 8'hA5),
            .init_wren  (1'b1),
            .ksa_addr   (kcnt[7:0] ^ 8'h3C),
            .ksa_data   (8'h5A),
            .ksa_wren   (~kcnt[0]),
            .prga_addr  (pcnt[7:0] + 8'h40),
            .prga_data  (8'hC3),
            .prga_wren  (1'b1),
            .mem_addr   (maddr_a[g]),
            .mem_data   (mdata_a[g]),
            .mem_wren   (mwren_a[g]),
            .busy       (busy_a[g]),
            .found      (found_a[g]),
            .exhausted  (exh_a[g]),
            .timeout_err(to_a[g])
        );
    end

    // Attempt and busy-cycle counters, restarted by each go pulse.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (go_a[i]) begin
                busy_cyc[i] = 0;
                att[i]      = 0;
            end else begin
                if (busy_a[i]) busy_cyc[i] = busy_cyc[i] + 1;
                if (ist_a[i] && !prev_ist[i]) att[i] = att[i] + 1;
            end
            prev_ist[i] = ist_a[i];
        end
    end

    typedef struct {
        int          inst;
        logic        ok_en;
        logic [23:0] ok_key;
        logic        stuck;
        logic        e_found;
        logic        e_exh;
        logic        e_to;
        logic [23:0] e_key;
        int          e_att;
        int          e_cyc;
    } vec_t;

    vec_t vecs [7];
    vec_t sb [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_go(input int i);
        @(posedge clk);
        #1 go_a[i] = 1'b1;
        @(posedge clk);
        #1 go_a[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i, input int limit, output logic ok);
        ok = 1'b0;
        for (int n = 0; n < limit; n++) begin
            @(negedge clk);
            if (!busy_a[i]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_vec(input vec_t v);
        vec_t e;
        logic ok;
        ok_en_a[v.inst]  = v.ok_en;
        ok_key_a[v.inst] = v.ok_key;
        stuck_a[v.inst]  = v.stuck;
        pulse_go(v.inst);
        sb.push_back(v);
        wait_idle(v.inst, 20000, ok);
        e = sb.pop_front();
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL wait_idle inst%0d: busy still 1 after 20000 cycles, required 0", e.inst);
        end else begin
            chk($sformatf("found i%0d", e.inst),   {31'd0, found_a[e.inst]}, {31'd0, e.e_found});
            chk($sformatf("exhaust i%0d", e.inst), {31'd0, exh_a[e.inst]},   {31'd0, e.e_exh});
            chk($sformatf("timeout i%0d", e.inst), {31'd0, to_a[e.inst]},    {31'd0, e.e_to});
            chk($sformatf("key i%0d", e.inst),     {8'd0, key_a[e.inst]},    {8'd0, e.e_key});
            chk($sformatf("attempts i%0d", e.inst), att[e.inst],             e.e_att);
            chk($sformatf("busy_cycles i%0d", e.inst), busy_cyc[e.inst],     e.e_cyc);
            chk($sformatf("starts_idle i%0d", e.inst),
                {29'd0, ist_a[e.inst], kst_a[e.inst], pst_a[e.inst]}, 32'd0);
        end
    endtask

    initial begin
        int   err_st, err_mem, err_bs, first_bad;
        int   khigh, early;
        logic ok;
        logic [2:0]  e_st;
        logic [7:0]  e_a, e_d;
        logic        e_w, e_busy, e_found;
        logic [15:0] off;

        for (int i = 0; i < NI; i++) begin
            rst_a[i] = 1'b0; go_a[i] = 1'b0; ok_en_a[i] = 1'b0;
            ok_key_a[i] = 24'd0; stuck_a[i] = 1'b0;
            busy_cyc[i] = 0; att[i] = 0; prev_ist[i] = 1'b0;
        end

        //                inst ok  okkey        stk fnd exh to  key          att cyc
        vecs[0] = '{0, 1'b1, 24'h000000, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000000, 1, 3423};
        vecs[1] = '{0, 1'b1, 24'h000003, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000003, 4, 13692};
        vecs[2] = '{1, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b1, 1'b0, 24'h3FFFFF, 2, 194};
        vecs[3] = '{2, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b1, 1'b0, 24'h3FFFFE, 1, 97};
        vecs[4] = '{1, 1'b1, 24'h3FFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 24'h3FFFFF, 2, 194};
        vecs[5] = '{3, 1'b1, 24'h000000, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000000, 1, 97};
        vecs[6] = '{3, 1'b0, 24'h000000, 1'b1, 1'b0, 1'b0, 1'b1, 24'h000000, 1, 123};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_key",     {8'd0, key_a[0]}, 32'd0);
        chk("reset_flags",   {28'd0, busy_a[0], found_a[0], exh_a[0], to_a[0]}, 32'd0);
        chk("reset_starts",  {29'd0, ist_a[0], kst_a[0], pst_a[0]}, 32'd0);
        chk("reset_mem",     {15'd0, maddr_a[0], mdata_a[0], mwren_a[0]}, 32'd0);
        for (int i = 0; i < NI; i++) rst_a[i] = 1'b1;

        // Cycle-by-cycle timeline of one full attempt on instance 0, with a
        // stray go in the middle of KSA that must be ignored.
        ok_en_a[0] = 1'b1; ok_key_a[0] = 24'h0;
        err_st = 0; err_mem = 0; err_bs = 0; first_bad = -1;
        pulse_go(0);
        for (int c = 0; c < 3425; c++) begin
            @(negedge clk);
            e_st = 3'b000; e_a = 8'h00; e_d = 8'h00; e_w = 1'b0;
            e_busy = (c < 3423); e_found = (c >= 3423);
            if (c < 257) begin
                off = 16'(c);
                e_st = 3'b100; e_a = off[7:0]; e_d = off[7:0] ^ 8'hA5; e_w = 1'b1;
            end else if (c >= 258 && c < 2819) begin
                off = 16'(c - 258);
                e_st = 3'b010; e_a = off[7:0] ^ 8'h3C; e_d = 8'h5A; e_w = ~off[0];
            end else if (c >= 2820 && c < 3421) begin
                off = 16'(c - 2820);
                e_st = 3'b001; e_a = off[7:0] + 8'h40; e_d = 8'hC3; e_w = 1'b1;
            end
            if ({ist_a[0], kst_a[0], pst_a[0]} !== e_st) begin
                err_st++; if (first_bad < 0) first_bad = c;
            end
            if ({maddr_a[0], mdata_a[0], mwren_a[0]} !== {e_a, e_d, e_w}) begin
                err_mem++; if (first_bad < 0) first_bad = c;
            end
            if ({busy_a[0], found_a[0], key_a[0]} !== {e_busy, e_found, 24'h0}) begin
                err_bs++; if (first_bad < 0) first_bad = c;
            end
            if (c == 1000) go_a[0] = 1'b1;
            if (c == 1001) go_a[0] = 1'b0;
        end
        if (first_bad >= 0) $display("timeline first deviation at cycle %0d", first_bad);
        chk("timeline_starts",   err_st,  0);
        chk("timeline_mem_mux",  err_mem, 0);
        chk("timeline_busy_key", err_bs,  0);

        for (int r = 0; r < 7; r++) run_vec(vecs[r]);

        // Stuck KSA on instance 3: watchdog must fire with the start held for
        // PHASE_TIMEOUT+1 cycles and timeout_err low until then.
        ok_en_a[3] = 1'b0; stuck_a[3] = 1'b1;
        khigh = 0; early = 0;
        pulse_go(3);
        ok = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            if (kst_a[3]) khigh++;
            if (kst_a[3] && to_a[3]) early++;
            if (!busy_a[3]) begin ok = 1'b1; break; end
        end
        chk("timeout_bounded", {31'd0, ok}, 32'd1);
        chk("timeout_ksa_run_cycles", khigh, 101);
        chk("timeout_not_early", early, 0);
        chk("timeout_flag", {31'd0, to_a[3]}, 32'd1);
        chk("timeout_fail_outputs",
            {26'd0, ist_a[3], kst_a[3], pst_a[3], mwren_a[3], found_a[3], exh_a[3]}, 32'd0);
        stuck_a[3] = 1'b0;

        // Asynchronous reset in the middle of the third attempt's PRGA.
        ok_en_a[0] = 1'b1; ok_key_a[0] = 24'h3;
        pulse_go(0);
        for (int c = 0; c <= 2 * 3423 + 2900; c++) @(negedge clk);
        chk("pre_reset_key",  {8'd0, key_a[0]}, 32'd2);
        chk("pre_reset_prga", {31'd0, pst_a[0]}, 32'd1);
        #2 rst_a[0] = 1'b0;
        #1;
        chk("async_reset_outputs",
            {24'd0, ist_a[0], kst_a[0], pst_a[0], mwren_a[0], busy_a[0], found_a[0], exh_a[0], to_a[0]},
            32'd0);
        chk("async_reset_key_mem", {8'd0, key_a[0] | {8'd0, maddr_a[0], mdata_a[0]}}, 32'd0);
        @(negedge clk);
        #2 rst_a[0] = 1'b1;
        run_vec('{0, 1'b1, 24'h000000, 1'b0, 1'b1, 1'b0, 1'b0, 24'h000000, 1, 3423});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
